sprite_addr_mux: RTL and testbench
==================================

SPRITE_ADDR_MUX -- requirements
Module: sprite_addr_mux

Interface
REQ-001 The block SHALL have parameter NUM_SPR, default 2, meaning number of sprite channels (1..8).
REQ-002 The block SHALL have parameter HALF_W, default 35, meaning sprite half-width in pixels.
REQ-003 The block SHALL have parameter HALF_H, default 25, meaning sprite half-height in pixels.
REQ-004 The block SHALL have parameter ADDR_W, default 13, meaning ROM address width; must satisfy NUM_SPR*(2*HALF_W)*(2*HALF_H) <= 2^ADDR_W.
REQ-005 The block SHALL have port clk  input  1  pixel clock; all state on rising edge.
REQ-006 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have ports hcount  input  11  and vcount  input  10, meaning current pixel column and row.
REQ-008 The block SHALL have port blank  input  1  meaning current pixel not displayed.
REQ-009 The block SHALL have port frame_start  input  1  meaning one-cycle strobe to load shadow position registers.
REQ-010 The block SHALL have port en  input  NUM_SPR  meaning per-channel enable, sampled with frame_start.
REQ-011 The block SHALL have ports x_bus and y_bus  input  16*NUM_SPR  each, meaning per-channel sprite centre; channel k occupies bits [16k+15:16k].
REQ-012 The block SHALL have port addr  output  ADDR_W  meaning sprite ROM address.
REQ-013 The block SHALL have port hit  output  1  meaning addr refers to a visible sprite pixel.
REQ-014 The block SHALL have port sprite_id  output  3  meaning index of the winning channel.

Function
REQ-015 The block SHALL load en, x_bus and y_bus into internal shadow registers on the cycle frame_start is high, and use only the shadow values for hit testing.
REQ-016 The block SHALL use the old shadow values for the pixel presented in the same cycle as frame_start, and the new values from the following cycle.
REQ-017 The block SHALL define W=2*HALF_W, H=2*HALF_H, col=hcount+HALF_W-x and row=vcount+HALF_H-y, all evaluated signed with at least 18 bits so that there is no wrap-around.
REQ-018 The block SHALL consider channel k inside when its shadow enable=1, blank=0, 0<=col<W and 0<=row<H.
REQ-019 In pipeline stage 1 the block SHALL register, per channel, the inside flag, row and col.
REQ-020 In pipeline stage 2 the block SHALL select the lowest-indexed inside channel, and register hit=1, sprite_id=k and addr=k*W*H+row*W+col, truncated to ADDR_W.
REQ-021 When no channel is inside, the block SHALL register hit=0, sprite_id=0 and addr=0.
REQ-022 Latency from hcount/vcount/blank input to addr/hit/sprite_id output SHALL be exactly 2 cycles, with a new result every cycle.
REQ-023 Overlapping sprites SHALL resolve by fixed priority, where channel 0 is highest.
REQ-024 A sprite partly off-screen (x<HALF_W or y<HALF_H) SHALL show only its visible portion, with no aliasing to the opposite edge.
REQ-025 Multiplication by W SHALL use a constant multiply; no multi-cycle arithmetic is permitted.

Reset
REQ-026 While reset is high, the block SHALL asynchronously clear the shadow enables, the shadow x and y, both pipeline stages, addr, hit and sprite_id to 0.
REQ-027 If reset is asserted mid-line, the block SHALL discard in-flight pixels, and the outputs SHALL remain 0 until two cycles after reset deasserts.
REQ-028 After reset, hit SHALL remain 0 until the first frame_start loads a nonzero en.

Configuration
REQ-029 Macro SPRITE_ADDR_MIRROR_EN SHALL control horizontal mirroring.
REQ-030 With SPRITE_ADDR_MIRROR_EN defined, the block SHALL add input port mirror  NUM_SPR, shadowed on frame_start, and a mirrored channel SHALL use col'=W-1-col in the address; the hit test is unchanged.
REQ-031 Without SPRITE_ADDR_MIRROR_EN, the block SHALL have no mirror port, SHALL always use col unmirrored, and SHALL contain no mirror logic.

Verification (NUM_SPR=2, defaults)
REQ-032 Corner test: ch0 x=100, y=100, en=01, frame_start; drive hcount=65, vcount=75 -> two cycles later hit=1, id=0, addr=0; hcount=134, vcount=124 -> addr=3499.
REQ-033 Edge test: same setup; hcount=135, vcount=100 -> hit=0, addr=0; hcount=64 -> hit=0; blank=1 at hcount=100 -> hit=0.
REQ-034 Priority test: both channels at (100,100), en=11 -> id=0; en=10 reloaded -> id=1 and addr=3500+row*70+col, e.g. hcount=65, vcount=75 gives 3500.
REQ-035 Shadow timing test: change x_bus without frame_start -> output unchanged; pulse frame_start coincident with a pixel -> that pixel uses old positions and the next pixel uses new positions.
REQ-036 Clipping test: ch0 x=10, y=5, hcount=0, vcount=0 -> hit=1, addr=20*70+25=1425; hcount=2047 -> hit=0.
REQ-037 Mirror and reset test: with SPRITE_ADDR_MIRROR_EN and mirror=01, hcount=65, vcount=75 -> addr=69; assert reset mid-stream -> all outputs 0 immediately and for 2 cycles after release.

Source files
------------

// File: rtl/sprite_addr_mux.sv
// Two-stage sprite hit-test and ROM address generator with frame-synchronous shadow positions.
// Optional horizontal mirroring is enabled by defining SPRITE_ADDR_MIRROR_EN.
module sprite_addr_mux #(
   parameter int NUM_SPR = 2,
   parameter int HALF_W  = 35,
   parameter int HALF_H  = 25,
   parameter int ADDR_W  = 13
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [10:0]            hcount,
   input  logic [9:0]             vcount,
   input  logic                   blank,
   input  logic                   frame_start,
   input  logic [NUM_SPR-1:0]     en,
   input  logic [16*NUM_SPR-1:0]  x_bus,
   input  logic [16*NUM_SPR-1:0]  y_bus,
`ifdef SPRITE_ADDR_MIRROR_EN
   input  logic [NUM_SPR-1:0]     mirror,
`endif
   output logic [ADDR_W-1:0]      addr,
   output logic                   hit,
   output logic [2:0]             sprite_id
);

   localparam int W  = 2 * HALF_W;
   localparam int H  = 2 * HALF_H;
   localparam int WH = W * H;
   // 20 bits holds hcount+HALF_W-x for any 16-bit x without wrapping.
   localparam int CW = 20;

   logic [NUM_SPR-1:0]    en_q;
   logic [16*NUM_SPR-1:0] x_q;
   logic [16*NUM_SPR-1:0] y_q;
`ifdef SPRITE_ADDR_MIRROR_EN
   logic [NUM_SPR-1:0]    mirror_q;
`endif

   logic [NUM_SPR-1:0]    ins_d, ins_q;
   logic [CW-1:0]         col_d [NUM_SPR];
   logic [CW-1:0]         row_d [NUM_SPR];
   logic [CW-1:0]         col_q [NUM_SPR];
   logic [CW-1:0]         row_q [NUM_SPR];

   logic [ADDR_W-1:0]     addr_d, addr_q;
   logic                  hit_d, hit_q;
   logic [2:0]            id_d, id_q;

   // Shadow registers: positions and enables change only on frame_start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
`ifdef SPRITE_ADDR_MIRROR_EN
         mirror_q <= '0;
`endif
      end else if (frame_start) begin
         en_q     <= en;
         x_q      <= x_bus;
         y_q      <= y_bus;
`ifdef SPRITE_ADDR_MIRROR_EN
         mirror_q <= mirror;
`endif
      end
   end

   // Stage 1 combinational: per-channel local coordinates and inside test.
   always_comb begin
      logic [CW-1:0] col_c;
      logic [CW-1:0] row_c;
      col_c = '0;
      row_c = '0;
      ins_d = '0;
      for (int k = 0; k < NUM_SPR; k++) begin
         col_c = CW'(hcount) + CW'(HALF_W) - CW'(x_q[16*k +: 16]);
         row_c = CW'(vcount) + CW'(HALF_H) - CW'(y_q[16*k +: 16]);
         ins_d[k] = en_q[k] & ~blank
                  & ~col_c[CW-1] & (col_c < CW'(W))
                  & ~row_c[CW-1] & (row_c < CW'(H));
`ifdef SPRITE_ADDR_MIRROR_EN
         col_d[k] = mirror_q[k] ? (CW'(W - 1) - col_c) : col_c;
`else
         col_d[k] = col_c;
`endif
         row_d[k] = row_c;
      end
   end

   // Stage 1 pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ins_q <= '0;
         for (int k = 0; k < NUM_SPR; k++) begin
            col_q[k] <= '0;
            row_q[k] <= '0;
         end
      end else begin
         ins_q <= ins_d;
         for (int k = 0; k < NUM_SPR; k++) begin
            col_q[k] <= col_d[k];
            row_q[k] <= row_d[k];
         end
      end
   end

   // Stage 2 combinational: descending scan so the lowest inside index wins.
   always_comb begin
      logic [31:0] sum_c;
      sum_c  = '0;
      hit_d  = 1'b0;
      id_d   = 3'd0;
      addr_d = '0;
      for (int k = NUM_SPR - 1; k >= 0; k--) begin
         sum_c  = 32'(k) * 32'(WH) + 32'(row_q[k]) * 32'(W) + 32'(col_q[k]);
         hit_d  = hit_d | ins_q[k];
         id_d   = ins_q[k] ? 3'(k) : id_d;
         addr_d = ins_q[k] ? ADDR_W'(sum_c) : addr_d;
      end
   end

   // Stage 2 output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q <= '0;
         hit_q  <= 1'b0;
         id_q   <= 3'd0;
      end else begin
         addr_q <= addr_d;
         hit_q  <= hit_d;
         id_q   <= id_d;
      end
   end

   assign addr      = addr_q;
   assign hit       = hit_q;
   assign sprite_id = id_q;

endmodule

// File: tb/tb_sprite_addr_mux.sv
// Self-checking bench for sprite_addr_mux (NUM_SPR=2, default geometry): directed table,
// mid-stream reset sequence, then randomized pixels against a behavioural model.
module tb_sprite_addr_mux;

   localparam int HW = 35;
   localparam int HH = 25;
   localparam int W  = 2 * HW;
   localparam int H  = 2 * HH;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] hcount = 11'd0;
   logic [9:0]  vcount = 10'd0;
   logic        blank = 1'b0;
   logic        frame_start = 1'b0;
   logic [1:0]  en = 2'b00;
   logic [31:0] x_bus = 32'd0;
   logic [31:0] y_bus = 32'd0;
   logic [12:0] addr;
   logic        hit;
   logic [2:0]  sprite_id;
`ifdef SPRITE_ADDR_MIRROR_EN
   logic [1:0]  mirror = 2'b00;
`endif

   sprite_addr_mux #(.NUM_SPR(2), .HALF_W(HW), .HALF_H(HH), .ADDR_W(13)) dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .blank(blank),
      .frame_start(frame_start), .en(en), .x_bus(x_bus), .y_bus(y_bus),
`ifdef SPRITE_ADDR_MIRROR_EN
      .mirror(mirror),
`endif
      .addr(addr), .hit(hit), .sprite_id(sprite_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        b;
      logic        fs;
      logic [1:0]  en;
      logic [15:0] x0, y0, x1, y1;
      logic        eh;
      logic [2:0]  eid;
      logic [12:0] ea;
   } vec_t;

   typedef struct {
      logic        h;
      logic [2:0]  id;
      logic [12:0] a;
   } exp_t;

   int   checks = 0;
   int   failures = 0;
   exp_t q[$];
   int   m_en[2], m_x[2], m_y[2];
   vec_t tbl[22];

   function automatic vec_t mk(int h, int v, int b, int fs, int e, int x0, int y0,
                               int x1, int y1, int eh, int eid, int ea);
      vec_t r;
      r.h = 11'(h); r.v = 10'(v); r.b = 1'(b); r.fs = 1'(fs); r.en = 2'(e);
      r.x0 = 16'(x0); r.y0 = 16'(y0); r.x1 = 16'(x1); r.y1 = 16'(y1);
      r.eh = 1'(eh); r.eid = 3'(eid); r.ea = 13'(ea);
      return r;
   endfunction

   // Reference: rectangle test in signed integers, first enabled channel wins.
   function automatic exp_t model(int h, int v, int b);
      exp_t r;
      int   col, row;
      r.h = 1'b0; r.id = 3'd0; r.a = 13'd0;
      for (int k = 1; k >= 0; k--) begin
         col = h + HW - m_x[k];
         row = v + HH - m_y[k];
         if (m_en[k] != 0 && b == 0 && col >= 0 && col < W && row >= 0 && row < H) begin
            r.h  = 1'b1;
            r.id = 3'(k);
            r.a  = 13'((k * W * H + row * W + col) % 8192);
         end
      end
      return r;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, ".hit"}, int'(hit), 0);
      check({name, ".id"}, int'(sprite_id), 0);
      check({name, ".addr"}, int'(addr), 0);
   endtask

   // Called at a negedge: compare the result due now, drive a new pixel, advance one cycle.
   task automatic step(input string name, input int h, input int v, input int b, input int fs,
                       input int e, input int x0, input int y0, input int x1, input int y1,
                       input bit use_tbl, input exp_t te);
      exp_t ex;
      if (q.size() >= 2) begin
         ex = q.pop_front();
         check({name, ".hit"}, int'(hit), int'(ex.h));
         check({name, ".id"}, int'(sprite_id), int'(ex.id));
         check({name, ".addr"}, int'(addr), int'(ex.a));
      end
      hcount = 11'(h); vcount = 10'(v); blank = 1'(b); frame_start = 1'(fs);
      en = 2'(e); x_bus = {16'(x1), 16'(x0)}; y_bus = {16'(y1), 16'(y0)};
      q.push_back(use_tbl ? te : model(h, v, b));
      if (fs != 0) begin
         m_en[0] = e & 1; m_en[1] = (e >> 1) & 1;
         m_x[0] = x0 & 16'hFFFF; m_x[1] = x1 & 16'hFFFF;
         m_y[0] = y0 & 16'hFFFF; m_y[1] = y1 & 16'hFFFF;
      end
      @(negedge clk);
   endtask

   task automatic model_clear();
      for (int k = 0; k < 2; k++) begin
         m_en[k] = 0; m_x[k] = 0; m_y[k] = 0;
      end
   endtask

   initial begin
      exp_t z;
      exp_t te;
      int   rx0, ry0, rx1, ry1, re, rh, rv;
      z.h = 1'b0; z.id = 3'd0; z.a = 13'd0;
      model_clear();

      //          h     v   b fs en  x0   y0   x1   y1  eh id addr
      tbl[0]  = mk(0,    0,  0, 1, 1, 100, 100, 0,   0,   0, 0, 0);
      tbl[1]  = mk(65,   75, 0, 0, 1, 100, 100, 0,   0,   1, 0, 0);
      tbl[2]  = mk(134, 124, 0, 0, 1, 100, 100, 0,   0,   1, 0, 3499);
      tbl[3]  = mk(135, 100, 0, 0, 1, 100, 100, 0,   0,   0, 0, 0);
      tbl[4]  = mk(64,  100, 0, 0, 1, 100, 100, 0,   0,   0, 0, 0);
      tbl[5]  = mk(100, 100, 1, 0, 1, 100, 100, 0,   0,   0, 0, 0);
      tbl[6]  = mk(100, 100, 0, 0, 1, 100, 100, 0,   0,   1, 0, 1785);
      tbl[7]  = mk(65,   75, 0, 1, 3, 100, 100, 100, 100, 1, 0, 0);
      tbl[8]  = mk(65,   75, 0, 0, 3, 100, 100, 100, 100, 1, 0, 0);
      tbl[9]  = mk(65,   75, 0, 1, 2, 100, 100, 100, 100, 1, 0, 0);
      tbl[10] = mk(65,   75, 0, 0, 2, 100, 100, 100, 100, 1, 1, 3500);
      tbl[11] = mk(100, 100, 0, 0, 2, 100, 100, 100, 100, 1, 1, 5285);
      tbl[12] = mk(65,   75, 0, 0, 2, 100, 100, 300, 100, 1, 1, 3500);
      tbl[13] = mk(65,   75, 0, 1, 2, 100, 100, 300, 100, 1, 1, 3500);
      tbl[14] = mk(65,   75, 0, 0, 2, 100, 100, 300, 100, 0, 0, 0);
      tbl[15] = mk(265,  75, 0, 0, 2, 100, 100, 300, 100, 1, 1, 3500);
      tbl[16] = mk(0,     0, 0, 1, 1, 10,  5,   300, 100, 0, 0, 0);
      tbl[17] = mk(0,     0, 0, 0, 1, 10,  5,   300, 100, 1, 0, 1425);
      tbl[18] = mk(2047,  0, 0, 0, 1, 10,  5,   300, 100, 0, 0, 0);
      tbl[19] = mk(44,    0, 0, 0, 1, 10,  5,   300, 100, 1, 0, 1469);
      tbl[20] = mk(0,    29, 0, 0, 1, 10,  5,   300, 100, 1, 0, 3455);
      tbl[21] = mk(0,    30, 0, 0, 1, 10,  5,   300, 100, 0, 0, 0);

      repeat (3) @(negedge clk);
      check_zero("reset_hold");
      reset = 1'b0;
      q.push_back(z);

      foreach (tbl[i]) begin
         te.h = tbl[i].eh; te.id = tbl[i].eid; te.a = tbl[i].ea;
         step($sformatf("vec%0d", i), int'(tbl[i].h), int'(tbl[i].v), int'(tbl[i].b),
              int'(tbl[i].fs), int'(tbl[i].en), int'(tbl[i].x0), int'(tbl[i].y0),
              int'(tbl[i].x1), int'(tbl[i].y1), 1'b1, te);
      end

      // Reset with hitting pixels in flight: outputs drop at once and stay 0.
      step("pre_rst", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      step("pre_rst", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      check("pre_rst.hit_live", int'(hit), 1);
      reset = 1'b1;
      #1;
      check_zero("rst_async");
      model_clear();
      @(negedge clk);
      check_zero("rst_mid1");
      @(negedge clk);
      check_zero("rst_mid2");
      reset = 1'b0;
      q.delete();
      q.push_back(z);
      step("post_rst", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      step("post_rst", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      step("post_rst", 0, 0, 0, 1, 1, 10, 5, 300, 100, 1'b0, z);
      step("reload", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      step("reload", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);
      step("reload", 0, 0, 0, 0, 1, 10, 5, 300, 100, 1'b0, z);

      rx0 = 100; ry0 = 100; rx1 = 120; ry1 = 110; re = 3;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 15) == 0) begin
            rx0 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 220));
            ry0 = int'($urandom_range(0, 220));
            rx1 = int'($urandom_range(0, 220));
            ry1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 220));
            re  = int'($urandom_range(0, 3));
            step("rand_fs", int'($urandom_range(0, 250)), int'($urandom_range(0, 250)),
                 int'($urandom_range(0, 7) == 0), 1, re, rx0, ry0, rx1, ry1, 1'b0, z);
         end else begin
            rh = ($urandom_range(0, 31) == 0) ? 2047 : int'($urandom_range(0, 250));
            rv = ($urandom_range(0, 31) == 0) ? 1023 : int'($urandom_range(0, 250));
            step("rand", rh, rv, int'($urandom_range(0, 7) == 0), 0,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 300)), ry0, rx1,
                 int'($urandom_range(0, 300)), 1'b0, z);
         end
      end
      step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, z);
      step("drain", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, z);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
